// File: rtl/fifo_wr_sched.sv
// rtl/fifo_wr_sched.sv - round-robin byte scheduler driving a timed USB FIFO write strobe
module fifo_wr_sched #(
    parameter int NREQ    = 2,
    parameter int SETUP_C = 1,
    parameter int PULSE_C = 2,
    parameter int RECOV_C = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                ft_n_txe,
    output logic [7:0]          ft_data,
    output logic                ft_n_wr,
    output logic                busy,
    output logic [1:0]          last_src
);

    localparam int CMAX = (SETUP_C > PULSE_C)
                        ? ((SETUP_C > RECOV_C) ? SETUP_C : RECOV_C)
                        : ((PULSE_C > RECOV_C) ? PULSE_C : RECOV_C);
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RECOV  = 2'd3
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           txe_meta_q;
    logic           txe_s_q;
    logic [7:0]     data_q;
    logic           n_wr_q;
    logic [1:0]     last_q;

    logic           grant_any;
    logic [1:0]     grant_idx;
    logic           grant_fire;
    logic [7:0]     grant_byte;

    // ft_n_txe is asynchronous to clk; power up and reset as "full"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txe_meta_q <= 1'b1;
            txe_s_q    <= 1'b1;
        end else begin
            txe_meta_q <= ft_n_txe;
            txe_s_q    <= txe_meta_q;
        end
    end

    // Scan from the highest offset down so the nearest source after last_q wins
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(last_q) + k) % NREQ]) begin
                grant_any = 1'b1;
                grant_idx = 2'((int'(last_q) + k) % NREQ);
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && en && !txe_s_q && grant_any;
    assign grant_byte = req_data[8*int'(grant_idx) +: 8];

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_fire && (int'(grant_idx) == i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_wr_q  <= 1'b1;
            data_q  <= 8'h00;
            last_q  <= 2'(NREQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        data_q  <= grant_byte;
                        last_q  <= grant_idx;
                        cnt_q   <= CW'(SETUP_C - 1);
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        n_wr_q  <= 1'b0;
                        cnt_q   <= CW'(PULSE_C - 1);
                        state_q <= STROBE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        n_wr_q  <= 1'b1;
                        cnt_q   <= CW'(RECOV_C - 1);
                        state_q <= RECOV;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RECOV: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ft_data  = data_q;
    assign ft_n_wr  = n_wr_q;
    assign busy     = (state_q != IDLE);
    assign last_src = last_q;

endmodule
